// File: rtl/cellrv32_pkg.sv
// Shared cellrv32 definitions: instruction-fetch responder state encoding,
// pending-request record and address-width helper.
package cellrv32_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT     = 3'd1,
    S_READ     = 3'd2,
    S_RESP     = 3'd3,
    S_PREFETCH = 3'd4
  } ifr_state_t;

  localparam int IFR_WAIT_MAX = 15;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic        cached;
  } ifr_req_t;

  // Number of address bits needed to index n bytes (ceil(log2(n))).
  function automatic int index_size_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cellrv32_ifetch_responder.sv
// Read-only instruction-fetch responder in front of an external word array,
// with configurable wait states and a one-word next-line prefetch buffer.
module cellrv32_ifetch_responder
  import cellrv32_pkg::*;
#(
  parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
  parameter int          MEM_SIZE    = 16384,
  parameter int          WAIT_STATES = 1,
  parameter bit          PREFETCH_EN = 1'b1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                clear_i,
  input  logic                                bus_cached_i,
  input  logic [31:0]                         bus_addr_i,
  input  logic                                bus_re_i,
  input  logic                                bus_we_i,
  output logic [31:0]                         bus_rdata_o,
  output logic                                bus_ack_o,
  output logic                                bus_err_o,
  output logic [index_size_f(MEM_SIZE)-3:0]   mem_addr_o,
  output logic                                mem_re_o,
  input  logic [31:0]                         mem_rdata_i,
  output logic                                pf_hit_o
);

  localparam int         AW = index_size_f(MEM_SIZE);
  localparam int         IW = AW - 2;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  if ((MEM_SIZE < 8) || ((MEM_SIZE & (MEM_SIZE - 1)) != 0)) begin : g_bad_size
    $error("cellrv32_ifetch_responder: MEM_SIZE must be a power of 2 and >= 8");
  end
  if ((MEM_BASE & 32'(MEM_SIZE - 1)) != 32'd0) begin : g_bad_base
    $error("cellrv32_ifetch_responder: MEM_BASE must be aligned to MEM_SIZE");
  end
  if ((WAIT_STATES < 0) || (WAIT_STATES > IFR_WAIT_MAX)) begin : g_bad_wait
    $error("cellrv32_ifetch_responder: WAIT_STATES must be in 0..15");
  end

  ifr_state_t    state;
  logic [3:0]    cnt;
  logic          pf_rd;
  logic [IW-1:0] req_idx;
  logic          req_cached;
  logic [IW-1:0] pf_idx;

  logic [31:0]   buf_data;
  logic [IW-1:0] buf_idx;
  logic          buf_valid;

  ifr_req_t      pend;
  logic          pend_valid;

  logic          hit_ack;
  logic [31:0]   hit_data;
  logic          err_q;
  logic          pf_hit_q;

  logic          bus_sel;
  ifr_req_t      cur;
  logic [IW-1:0] cur_idx;
  logic [IW-1:0] cur_nxt;
  logic [IW-1:0] req_nxt;
  logic          cur_hit;
  logic          cur_bad;
  logic          cur_pf;
  logic          req_pf;
  logic          pf_issue;

  assign bus_sel = (bus_re_i | bus_we_i) && (bus_addr_i[31:AW] == MEM_BASE[31:AW]);

  // A request parked during a prefetch takes priority over the live bus.
  always_comb begin
    cur = '{addr: bus_addr_i, we: bus_we_i, cached: bus_cached_i};
    if (pend_valid) cur = pend;
  end

  assign cur_idx  = cur.addr[AW-1:2];
  assign cur_nxt  = cur_idx + IW'(1);
  assign req_nxt  = req_idx + IW'(1);
  assign cur_hit  = buf_valid && (buf_idx == cur_idx);
  assign cur_bad  = cur.we || (cur.addr[1:0] != 2'b00);
  assign cur_pf   = PREFETCH_EN && cur.cached && (cur_nxt != '0);
  assign req_pf   = PREFETCH_EN && req_cached && (req_nxt != '0);
  assign pf_issue = (state == S_PREFETCH) && (cnt == 4'd0) && !pf_rd;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      pf_rd      <= 1'b0;
      req_idx    <= '0;
      req_cached <= 1'b0;
      pf_idx     <= '0;
      buf_data   <= 32'd0;
      buf_idx    <= '0;
      buf_valid  <= 1'b0;
      pend       <= '0;
      pend_valid <= 1'b0;
      hit_ack    <= 1'b0;
      hit_data   <= 32'd0;
      err_q      <= 1'b0;
      pf_hit_q   <= 1'b0;
    end else begin
      hit_ack  <= 1'b0;
      hit_data <= 32'd0;
      err_q    <= 1'b0;
      pf_hit_q <= 1'b0;
      if (clear_i) buf_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (pend_valid || bus_sel) begin
            pend_valid <= 1'b0;
            if (cur_bad) begin
              err_q <= 1'b1;
            end else if (cur_hit) begin
              hit_ack  <= 1'b1;
              hit_data <= buf_data;
              pf_hit_q <= 1'b1;
              if (cur_pf) begin
                state  <= S_PREFETCH;
                pf_idx <= cur_nxt;
                cnt    <= WS;
                pf_rd  <= 1'b0;
              end
            end else begin
              req_idx    <= cur_idx;
              req_cached <= cur.cached;
              cnt        <= WS;
              state      <= (WS == 4'd0) ? S_READ : S_WAIT;
            end
          end
        end

        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= S_READ;
        end

        S_READ: state <= S_RESP;

        S_RESP: begin
          if (req_pf) begin
            state  <= S_PREFETCH;
            pf_idx <= req_nxt;
            cnt    <= WS;
            pf_rd  <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end

        S_PREFETCH: begin
          if (bus_sel && !pend_valid) begin
            pend       <= '{addr: bus_addr_i, we: bus_we_i, cached: bus_cached_i};
            pend_valid <= 1'b1;
          end
          // Clear aborts at any point, including the capture cycle.
          if (clear_i) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            pf_rd <= 1'b0;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!pf_rd) begin
            pf_rd <= 1'b1;
          end else begin
            buf_data  <= mem_rdata_i;
            buf_idx   <= pf_idx;
            buf_valid <= 1'b1;
            pf_rd     <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_rdata_o = 32'd0;
    if (state == S_RESP) bus_rdata_o = mem_rdata_i;
    else if (hit_ack)    bus_rdata_o = hit_data;
  end

  always_comb begin
    mem_addr_o = '0;
    if (state == S_READ) mem_addr_o = req_idx;
    else if (pf_issue)   mem_addr_o = pf_idx;
  end

  assign bus_ack_o = (state == S_RESP) || hit_ack;
  assign bus_err_o = err_q;
  assign mem_re_o  = (state == S_READ) || pf_issue;
  assign pf_hit_o  = pf_hit_q;

endmodule

// File: tb/tb_cellrv32_ifetch_responder.sv
// Bench for cellrv32_ifetch_responder: directed vector table, hand-built
// multi-cycle corner sequences and a randomized run against a buffer model.
module tb_cellrv32_ifetch_responder;

  localparam int WS       = 2;
  localparam int MEM_SIZE = 16384;
  localparam int IW       = 12;
  localparam int LAST_IDX = 4095;
  localparam int A_MISS   = WS + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        cached;
  logic [31:0] addr;
  logic        re;
  logic        we;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic [IW-1:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        pf_hit;

  always #5 clk = ~clk;

  cellrv32_ifetch_responder #(
    .MEM_BASE    (32'h0000_0000),
    .MEM_SIZE    (MEM_SIZE),
    .WAIT_STATES (WS),
    .PREFETCH_EN (1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (clear),
    .bus_cached_i (cached),
    .bus_addr_i   (addr),
    .bus_re_i     (re),
    .bus_we_i     (we),
    .bus_rdata_o  (rdata),
    .bus_ack_o    (ack),
    .bus_err_o    (err),
    .mem_addr_o   (mem_addr),
    .mem_re_o     (mem_re),
    .mem_rdata_i  (mem_rdata),
    .pf_hit_o     (pf_hit)
  );

  function automatic logic [31:0] memw(input logic [IW-1:0] i);
    return 32'h5A00_0077 ^ ({20'h0, i} * 32'h0001_0003);
  endfunction

  // External array: data valid the cycle after mem_re, noise otherwise.
  always @(posedge clk) mem_rdata <= mem_re ? memw(mem_addr) : $urandom;

  int n_checks = 0;
  int n_errors = 0;
  int leak = 0;
  int mre_first, mre_last;
  logic [IW-1:0] mre_first_idx, mre_last_idx;
  logic [5:0] rst_outs;
  logic [47:0] exp_q[$];
  logic [47:0] obs_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response record: {err, ack, pf_hit, cycle[12:0], rdata}
  function automatic logic [47:0] rsp(input logic [1:0] kind, input bit hit, input int cyc,
                                      input logic [31:0] d);
    return {kind, hit, 13'(cyc), d};
  endfunction

  task automatic run_seq(input logic [31:0] a0, input bit we0, input bit c0,
                         input int sec_c, input logic [31:0] a1, input bit we1, input bit c1,
                         input int clr_c, input int rst_c, input int window);
    obs_q.delete();
    mre_first = -1;
    mre_last  = -1;
    rst_outs  = '0;
    for (int c = 0; c < window; c++) begin
      re     = (c == 0 && !we0) || (c == sec_c && !we1);
      we     = (c == 0 && we0) || (c == sec_c && we1);
      addr   = (c == sec_c) ? a1 : a0;
      cached = (c == sec_c) ? c1 : c0;
      clear  = (c == clr_c);
      rst    = (c == rst_c);
      @(negedge clk);
      if (ack || err || pf_hit) obs_q.push_back({err, ack, pf_hit, 13'(c), rdata});
      if (!ack && rdata != 32'd0) leak++;
      if (mem_re) begin
        if (mre_first < 0) begin
          mre_first     = c;
          mre_first_idx = mem_addr;
        end
        mre_last     = c;
        mre_last_idx = mem_addr;
      end
      if (c == rst_c) rst_outs = {ack, err, pf_hit, mem_re, |rdata, |mem_addr};
      @(posedge clk);
      #1;
    end
    re = 0; we = 0; clear = 0; rst = 0; cached = 0; addr = 0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic score(input string name);
    check({name, " count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) check(name, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          we;
    bit          cached;
    bit          clr;
    logic [1:0]  kind;
    bit          hit;
    int          cyc;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] r2;
    bit   mvalid;
    int   midx;
    int   prev_idx;

    tbl[0]  = '{32'h0000_0010, 0, 0, 0, 2'b01, 0, A_MISS, memw(12'd4)};
    tbl[1]  = '{32'h0000_0040, 0, 1, 0, 2'b01, 0, A_MISS, memw(12'd16)};
    tbl[2]  = '{32'h0000_0044, 0, 1, 0, 2'b01, 1, 1, memw(12'd17)};
    tbl[3]  = '{32'h0000_0048, 0, 1, 0, 2'b01, 1, 1, memw(12'd18)};
    tbl[4]  = '{32'h0000_004C, 0, 1, 0, 2'b01, 1, 1, memw(12'd19)};
    tbl[5]  = '{32'h0000_0008, 1, 0, 0, 2'b10, 0, 1, 32'd0};
    tbl[6]  = '{32'h0000_0006, 0, 0, 0, 2'b10, 0, 1, 32'd0};
    tbl[7]  = '{32'h0001_0000, 0, 0, 0, 2'b00, 0, 0, 32'd0};
    tbl[8]  = '{32'h0000_0050, 0, 0, 0, 2'b01, 1, 1, memw(12'd20)};
    tbl[9]  = '{32'h0000_0050, 0, 0, 0, 2'b01, 1, 1, memw(12'd20)};
    tbl[10] = '{32'h0000_0100, 0, 0, 0, 2'b01, 0, A_MISS, memw(12'd64)};
    tbl[11] = '{32'h0000_0050, 0, 0, 0, 2'b01, 1, 1, memw(12'd20)};
    tbl[12] = '{32'h0000_0050, 0, 0, 1, 2'b01, 0, A_MISS, memw(12'd20)};
    tbl[13] = '{32'h0000_3FFC, 0, 1, 0, 2'b01, 0, A_MISS, memw(12'd4095)};
    tbl[14] = '{32'h0000_0000, 0, 0, 0, 2'b01, 0, A_MISS, memw(12'd0)};
    tbl[15] = '{32'h0000_4000, 0, 0, 0, 2'b00, 0, 0, 32'd0};

    // Clock/reset
    rst = 1; clear = 0; cached = 0; addr = 0; re = 0; we = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ack", ack, 0);
    check("reset err", err, 0);
    check("reset pf_hit", pf_hit, 0);
    check("reset mem_re", mem_re, 0);
    check("reset rdata", rdata, 0);
    check("reset mem_addr", mem_addr, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].clr) pulse_clear();
      run_seq(tbl[i].addr, tbl[i].we, tbl[i].cached, -1, 32'd0, 0, 0, -1, -1, 20);
      if (tbl[i].kind != 2'b00) exp_q.push_back(rsp(tbl[i].kind, tbl[i].hit, tbl[i].cyc, tbl[i].data));
      score($sformatf("vec%0d", i));
    end

    // Miss path array access timing, no prefetch for uncached read
    pulse_clear();
    run_seq(32'h10, 0, 0, -1, 32'd0, 0, 0, -1, -1, 20);
    check("miss mem_re cycle", mre_first, WS + 1);
    check("miss mem_re index", mre_first_idx, 4);
    check("uncached no prefetch", mre_last, WS + 1);
    exp_q.push_back(rsp(2'b01, 0, A_MISS, memw(12'd4)));
    score("miss 0x10");

    // Request arriving during a prefetch is parked, then hits the buffer
    pulse_clear();
    run_seq(32'h20, 0, 1, WS + 4, 32'h24, 0, 1, -1, -1, 30);
    check("pend count", obs_q.size(), 2);
    if (obs_q.size() >= 1) check("pend first", obs_q.pop_front(), rsp(2'b01, 0, A_MISS, memw(12'd8)));
    if (obs_q.size() >= 1) begin
      r2 = obs_q.pop_front();
      check("pend kind/hit", r2[47:45], 3'b011);
      check("pend data", r2[31:0], memw(12'd9));
      check("pend after capture", (r2[44:32] >= 13'(2*WS + 5)) && (r2[44:32] <= 13'(2*WS + 7)), 1);
    end
    obs_q.delete();

    // Clear in the capture cycle of the prefetch for 0x24
    pulse_clear();
    run_seq(32'h20, 0, 1, -1, 32'd0, 0, 0, 2*WS + 4, -1, 20);
    check("pf read cycle", mre_last, 2*WS + 3);
    check("pf read index", mre_last_idx, 9);
    exp_q.push_back(rsp(2'b01, 0, A_MISS, memw(12'd8)));
    score("clr capture first");
    run_seq(32'h24, 0, 0, -1, 32'd0, 0, 0, -1, -1, 20);
    exp_q.push_back(rsp(2'b01, 0, A_MISS, memw(12'd9)));
    score("clr capture reread");

    // Reset pulse while waiting
    run_seq(32'h0, 0, 0, -1, 32'd0, 0, 0, -1, 1, 16);
    check("rst outputs", rst_outs, 0);
    score("rst abort");
    run_seq(32'h0, 0, 0, -1, 32'd0, 0, 0, -1, -1, 16);
    exp_q.push_back(rsp(2'b01, 0, A_MISS, memw(12'd0)));
    score("after rst");

    // Randomized run against a one-entry buffer model
    mvalid = 0;
    midx = 0;
    prev_idx = 0;
    for (int t = 0; t < 80; t++) begin
      int r, widx, sel_r;
      logic [31:0] a;
      bit w, c;
      if ($urandom_range(0, 99) < 8) begin
        pulse_clear();
        mvalid = 0;
      end
      r = $urandom_range(0, 99);
      if (r < 55)      widx = (prev_idx + 1) % (LAST_IDX + 1);
      else if (r < 92) widx = $urandom_range(0, 31);
      else             widx = $urandom_range(LAST_IDX - 1, LAST_IDX);
      prev_idx = widx;
      a = 32'(widx) << 2;
      w = 0;
      sel_r = $urandom_range(0, 99);
      if (sel_r < 6)       w = 1;
      else if (sel_r < 12) a = a | 32'($urandom_range(1, 3));
      else if (sel_r < 18) a = a | (32'h4000 << $urandom_range(0, 17));
      c = ($urandom_range(0, 99) < 70);

      if (a[31:14] != 18'd0) begin
        // unselected: no response
      end else if (w || a[1:0] != 2'b00) begin
        exp_q.push_back(rsp(2'b10, 0, 1, 32'd0));
      end else begin
        if (mvalid && midx == widx) exp_q.push_back(rsp(2'b01, 1, 1, memw(12'(widx))));
        else                        exp_q.push_back(rsp(2'b01, 0, A_MISS, memw(12'(widx))));
        if (c && widx != LAST_IDX) begin
          mvalid = 1;
          midx = widx + 1;
        end
      end
      run_seq(a, w, c, -1, 32'd0, 0, 0, -1, -1, 16);
      score($sformatf("rand%0d addr %0h", t, a));
    end

    check("rdata zero outside ack", leak, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cellrv32_ifetch_responder.md
CELLRV32_IFETCH_RESPONDER -- requirements
Module: cellrv32_ifetch_responder

Interface
REQ-001 SHALL have parameter MEM_BASE, default 32'h00000000, region base address (aligned to MEM_SIZE).
REQ-002 SHALL have parameter MEM_SIZE, default 16384, region size in bytes (power of 2, >= 8).
REQ-003 SHALL have parameter WAIT_STATES, default 1, extra cycles per array read (0..15).
REQ-004 SHALL have parameter PREFETCH_EN, default 1, enables the next-word prefetch buffer.
REQ-005 SHALL have ports, in this order:
- clk_i  in  1  global clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- clear_i  in  1  invalidate prefetch buffer
- bus_cached_i  in  1  request is part of a cache block download
- bus_addr_i  in  32  access address
- bus_re_i  in  1  read request, one-cycle pulse
- bus_we_i  in  1  write request, one-cycle pulse
- bus_rdata_o  out  32  read data
- bus_ack_o  out  1  transfer acknowledge
- bus_err_o  out  1  transfer error
- mem_addr_o  out  log2(MEM_SIZE)-2  word index into read-only array
- mem_re_o  out  1  array read enable
- mem_rdata_i  in  32  array data, valid one cycle after mem_re_o
- pf_hit_o  out  1  one-cycle pulse when a request is served from the prefetch buffer

Function
REQ-006 SHALL select a request only when bus_addr_i[31:log2(MEM_SIZE)] equals MEM_BASE[31:log2(MEM_SIZE)]; unselected requests SHALL get no response and cause no state change.
REQ-007 SHALL answer each selected request with exactly one single-cycle pulse on either bus_ack_o or bus_err_o, never both.
REQ-008 bus_rdata_o SHALL carry data only in the ack cycle and SHALL be zero otherwise.
REQ-009 SHALL answer a selected write, or a read with bus_addr_i[1:0] != 0, with bus_err_o in cycle 1 (request cycle = 0).
REQ-010 SHALL implement FSM states S_IDLE, S_WAIT, S_READ, S_RESP and S_PREFETCH.
REQ-011 Buffer-miss read path:
- S_IDLE -> S_WAIT with counter = WAIT_STATES; skip directly to S_READ when WAIT_STATES = 0.
- S_WAIT -> S_READ when the counter reaches 0.
- S_READ asserts mem_re_o and mem_addr_o = address[log2(MEM_SIZE)-1:2] -> S_RESP.
- S_RESP drives ack with mem_rdata_i.
- Resulting ack cycle = WAIT_STATES + 2.
REQ-012 Prefetch buffer: holds one data word, a word index and a valid flag.
- A read matching a valid buffer entry SHALL ack in cycle 1 with buffered data and pulse pf_hit_o; buffer-hit reads bypass wait states.
REQ-013 After acking any read with bus_cached_i = 1, with PREFETCH_EN = 1 and next index != 0 (no wrap):
- SHALL enter S_PREFETCH, apply the same wait-state count, and read index+1 into the buffer.
- SHALL set valid when the data is captured.
REQ-014 A selected request arriving during S_PREFETCH SHALL be latched into a one-entry pending register and served after the prefetch completes, buffer hit check included; no request SHALL be lost.
REQ-015 Selected requests arriving in S_WAIT, S_READ or S_RESP SHALL be ignored (protocol violation; the initiator issues one request at a time).
REQ-016 clear_i SHALL invalidate the buffer next cycle.
- clear_i during S_PREFETCH SHALL abort the prefetch, leaving valid = 0.
- clear_i coincident with the capture cycle: clear wins.
REQ-017 A read whose address misses the buffer SHALL leave the buffer unchanged until a new prefetch overwrites it.

Reset
REQ-018 While rst_i = 1, SHALL force: state S_IDLE, buffer valid 0, pending 0, wait counter 0, all outputs 0.
REQ-019 Reset asserted mid-transfer SHALL abort it with no response pulse, before or after release.

Structure
REQ-020 The state enum typedef SHALL reside in the shared cellrv32 package, and index width SHALL be derived with the package's existing index_size_f.
REQ-021 The block SHALL contain no sub-module; the memory array is external, and the prefetch buffer is inline registers.
REQ-022 Sanity checks SHALL flag a non-power-of-2 MEM_SIZE, a misaligned MEM_BASE, and WAIT_STATES > 15.

Verification
REQ-023 WAIT_STATES = 1, read 0x00000010, cached = 0 -> mem_re_o in cycle 2 with index 4, ack in cycle 3, rdata = array[4], no prefetch.
REQ-024 Block download of 0x40..0x4C, cached = 1, WAIT_STATES = 2 -> first ack in cycle 4; each following word acks 1 cycle after request with pf_hit_o = 1.
REQ-025 Write to 0x00000008, or read of 0x00000006 -> bus_err_o in cycle 1 and rdata = 0; read of 0x00010000 with MEM_SIZE = 16384 -> no response for 20 cycles.
REQ-026 Read 0x20 (cached), then re-request 0x24 during S_PREFETCH -> request pended and served from the buffer once capture completes; exactly one ack.
REQ-027 clear_i in the capture cycle of a prefetch for 0x24, then read 0x24 -> full-latency miss path, pf_hit_o = 0.
REQ-028 rst_i pulsed in S_WAIT -> no ack/err, all outputs 0; next read 0x0 completes normally.
